credit_scheduler: RTL and testbench

Sequencing controller behind the main-screen credit circles. Turns raw ball/credit collision pulses into at most one award per hit, keeps a per-credit value counter, applies a per-credit frame-based cooldown, and hands the award to the score path over a valid/ready handshake. It also serves the value of whichever credit the pixel pipeline is drawing, and optionally rotates a double-value bonus credit.

---
 rtl/credit_scheduler_if.sv | 9 +
 rtl/credit_scheduler.sv | 131 +++++++++++++
 tb/tb_credit_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/credit_scheduler_if.sv
// Award handshake between the credit scheduler (master) and the score path (slave).
interface credit_scheduler_if;
    logic       scoreValid;
    logic       scoreReady;
    logic [7:0] scoreAmount;

    modport master (output scoreValid, output scoreAmount, input scoreReady);
    modport slave  (input scoreValid, input scoreAmount, output scoreReady);
endinterface

// File: rtl/credit_scheduler.sv
// Credit-circle award sequencer: hit filtering, per-credit value/cooldown, score handshake.
// Optional double-value rotating bonus credit enabled by defining CREDIT_BONUS_EN.
module credit_scheduler #(
    parameter int NUM_CREDITS         = 4,
    parameter int INIT_VALUE          = 1,
    parameter int MAX_VALUE           = 9,
    parameter int COOLDOWN_FRAMES     = 30,
    parameter int BONUS_PERIOD_FRAMES = 120
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic [3:0]                 creditIndex,
    input  logic                       collisionBallCredit,
    input  logic                       startOfFrame,
    credit_scheduler_if.master         score,
    output logic [3:0]                 number,
    output logic [3:0]                 bonusIndex
);
    localparam int IW = (NUM_CREDITS > 1) ? $clog2(NUM_CREDITS) : 1;
    localparam int CW = $clog2(COOLDOWN_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, AWARD, UPDATE} state_t;

    state_t        state_reg, state_next;
    logic [3:0]    value_arr    [NUM_CREDITS];
    logic [CW-1:0] cooldown_arr [NUM_CREDITS];
    logic [IW-1:0] hit_idx_reg;
    logic [IW-1:0] sel_idx;
    logic [7:0]    amount_reg, amount_next;
    logic          idx_ok, accept;

    assign idx_ok  = {1'b0, creditIndex} < 5'(NUM_CREDITS);
    assign sel_idx = creditIndex[IW-1:0];
    assign accept  = (state_reg == IDLE) && collisionBallCredit && idx_ok
                     && (cooldown_arr[sel_idx] == '0);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = AWARD;
            AWARD:   if (score.scoreReady) state_next = UPDATE;
            UPDATE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        score.scoreValid  = (state_reg == AWARD);
        score.scoreAmount = amount_reg;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hit_idx_reg <= '0;
            amount_reg  <= 8'd0;
        end else if (accept) begin
            hit_idx_reg <= sel_idx;
            amount_reg  <= amount_next;
        end
    end

    for (genvar gi = 0; gi < NUM_CREDITS; gi++) begin : g_credit
        logic [3:0]    value_reg;
        logic [CW-1:0] cooldown_reg;

        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN)
                value_reg <= 4'(INIT_VALUE);
            else if (state_reg == UPDATE && hit_idx_reg == IW'(gi))
                value_reg <= (value_reg >= 4'(MAX_VALUE)) ? 4'(INIT_VALUE) : value_reg + 4'd1;
        end

        // A fresh acceptance outranks the frame-tick decrement in the same cycle.
        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN)
                cooldown_reg <= '0;
            else if (accept && sel_idx == IW'(gi))
                cooldown_reg <= CW'(COOLDOWN_FRAMES);
            else if (startOfFrame && cooldown_reg != '0)
                cooldown_reg <= cooldown_reg - CW'(1);
        end

        assign value_arr[gi]    = value_reg;
        assign cooldown_arr[gi] = cooldown_reg;
    end

    always_comb begin
        number = 4'(INIT_VALUE);
        if (idx_ok) number = value_arr[sel_idx];
    end

`ifdef CREDIT_BONUS_EN
    localparam int FW = (BONUS_PERIOD_FRAMES > 1) ? $clog2(BONUS_PERIOD_FRAMES) : 1;

    logic [FW-1:0] frame_cnt_reg;
    logic [IW-1:0] bonus_idx_reg;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            frame_cnt_reg <= '0;
            bonus_idx_reg <= '0;
        end else if (startOfFrame) begin
            if (frame_cnt_reg == FW'(BONUS_PERIOD_FRAMES - 1)) begin
                frame_cnt_reg <= '0;
                bonus_idx_reg <= (bonus_idx_reg == IW'(NUM_CREDITS - 1)) ? '0
                                                                          : bonus_idx_reg + IW'(1);
            end else begin
                frame_cnt_reg <= frame_cnt_reg + FW'(1);
            end
        end
    end

    always_comb begin
        amount_next = {4'd0, value_arr[sel_idx]};
        if (sel_idx == bonus_idx_reg) amount_next = {3'd0, value_arr[sel_idx], 1'b0};
    end

    assign bonusIndex = 4'(bonus_idx_reg);
`else
    always_comb begin
        amount_next = {4'd0, value_arr[sel_idx]};
    end

    assign bonusIndex = 4'd0;
`endif
endmodule

// File: tb/tb_credit_scheduler.sv
// Directed self-checking bench for credit_scheduler (bonus scenario only when CREDIT_BONUS_EN is defined).
module tb_credit_scheduler;
    localparam int NUM  = 4;
    localparam int COOL = 30;
`ifdef CREDIT_BONUS_EN
    localparam int BP       = 2;
    localparam bit BONUS_ON = 1'b1;
`else
    localparam int BP       = 120;
    localparam bit BONUS_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic [3:0] creditIndex = 4'd0;
    logic       collisionBallCredit = 1'b0;
    logic       startOfFrame = 1'b0;
    logic [3:0] number;
    logic [3:0] bonusIndex;

    int vectors = 0;
    int errors  = 0;
    int frames  = 0;

    credit_scheduler_if sif();

    credit_scheduler #(
        .NUM_CREDITS(NUM), .INIT_VALUE(1), .MAX_VALUE(9),
        .COOLDOWN_FRAMES(COOL), .BONUS_PERIOD_FRAMES(BP)
    ) dut (
        .clk(clk), .resetN(resetN), .creditIndex(creditIndex),
        .collisionBallCredit(collisionBallCredit), .startOfFrame(startOfFrame),
        .score(sif), .number(number), .bonusIndex(bonusIndex)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        frames++;
        tick();
    endtask

    // Expected doubling factor for an acceptance on credit idx, from frames counted since reset.
    function automatic int mult(int idx);
        return (BONUS_ON && idx == (frames / BP) % NUM) ? 2 : 1;
    endfunction

    task automatic test_reset();
        resetN = 1'b0;
        repeat (2) tick();
        vectors++;
        if (sif.scoreValid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %0b expected 0", sif.scoreValid);
        end
        vectors++;
        if (sif.scoreAmount !== 8'd0) begin
            errors++; $display("FAIL reset_amount: got %0d expected 0", sif.scoreAmount);
        end
        vectors++;
        if (bonusIndex !== 4'd0) begin
            errors++; $display("FAIL reset_bonus: got %0d expected 0", bonusIndex);
        end
        for (int k = 0; k < NUM; k++) begin
            creditIndex = 4'(k);
            #1;
            vectors++;
            if (number !== 4'd1) begin
                errors++; $display("FAIL reset_number[%0d]: got %0d expected 1", k, number);
            end
        end
        resetN = 1'b1;
        frames = 0;
        tick();
        $display("reset done");
    endtask

    task automatic test_single_hit();
        int exp_amt;
        sif.scoreReady = 1'b1;
        creditIndex = 4'd2;
        collisionBallCredit = 1'b1;
        exp_amt = 1 * mult(2);
        tick();
        collisionBallCredit = 1'b0;
        vectors++;
        if (sif.scoreValid !== 1'b1 || sif.scoreAmount !== 8'(exp_amt)) begin
            errors++; $display("FAIL single_award: got valid %0b amount %0d expected valid 1 amount %0d",
                               sif.scoreValid, sif.scoreAmount, exp_amt);
        end
        tick();
        vectors++;
        if (sif.scoreValid !== 1'b0) begin
            errors++; $display("FAIL single_pulse: got valid %0b expected 0", sif.scoreValid);
        end
        tick();
        vectors++;
        if (number !== 4'd2) begin
            errors++; $display("FAIL single_number: got %0d expected 2", number);
        end
        $display("single hit credit 2 amount %0d", exp_amt);
    endtask

    task automatic test_cooldown();
        int awards = 0;
        int exp_amt;
        creditIndex = 4'd1;
        collisionBallCredit = 1'b1;
        tick();
        if (sif.scoreValid === 1'b1) awards++;
        for (int f = 0; f < 10; f++) begin
            startOfFrame = 1'b1;
            tick();
            if (sif.scoreValid === 1'b1) awards++;
            startOfFrame = 1'b0;
            frames++;
            for (int c = 0; c < 4; c++) begin
                tick();
                if (sif.scoreValid === 1'b1) awards++;
            end
        end
        collisionBallCredit = 1'b0;
        vectors++;
        if (awards !== 1) begin
            errors++; $display("FAIL cooldown_held: got %0d award cycles expected 1", awards);
        end
        repeat (19) frame();
        collisionBallCredit = 1'b1;
        tick();
        collisionBallCredit = 1'b0;
        vectors++;
        if (sif.scoreValid !== 1'b0) begin
            errors++; $display("FAIL cooldown_29: got valid %0b expected 0", sif.scoreValid);
        end
        frame();
        exp_amt = 2 * mult(1);
        collisionBallCredit = 1'b1;
        tick();
        collisionBallCredit = 1'b0;
        vectors++;
        if (sif.scoreValid !== 1'b1 || sif.scoreAmount !== 8'(exp_amt)) begin
            errors++; $display("FAIL cooldown_30: got valid %0b amount %0d expected valid 1 amount %0d",
                               sif.scoreValid, sif.scoreAmount, exp_amt);
        end
        tick();
        tick();
        $display("cooldown credit 1 re-award amount %0d", exp_amt);
    endtask

    task automatic test_stall();
        int exp_amt;
        int bad = 0;
        sif.scoreReady = 1'b0;
        creditIndex = 4'd2;
        collisionBallCredit = 1'b1;
        exp_amt = 2 * mult(2);
        tick();
        creditIndex = 4'd3;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (sif.scoreValid !== 1'b1 || sif.scoreAmount !== 8'(exp_amt)) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            errors++; $display("FAIL stall_stable: got %0d unstable cycles expected 0 (amount %0d)", bad, exp_amt);
        end
        collisionBallCredit = 1'b0;
        sif.scoreReady = 1'b1;
        tick();
        vectors++;
        if (sif.scoreValid !== 1'b0) begin
            errors++; $display("FAIL stall_release: got valid %0b expected 0", sif.scoreValid);
        end
        tick();
        exp_amt = 1 * mult(3);
        collisionBallCredit = 1'b1;
        tick();
        collisionBallCredit = 1'b0;
        vectors++;
        if (sif.scoreValid !== 1'b1 || sif.scoreAmount !== 8'(exp_amt)) begin
            errors++; $display("FAIL stall_credit3: got valid %0b amount %0d expected valid 1 amount %0d",
                               sif.scoreValid, sif.scoreAmount, exp_amt);
        end
        tick();
        tick();
        $display("stall done, credit 3 awarded %0d", exp_amt);
    endtask

    task automatic test_wrap();
        int exp_amt;
        creditIndex = 4'd0;
        for (int n = 0; n < 10; n++) begin
            exp_amt = ((n % 9) + 1) * mult(0);
            collisionBallCredit = 1'b1;
            tick();
            collisionBallCredit = 1'b0;
            vectors++;
            if (sif.scoreValid !== 1'b1 || sif.scoreAmount !== 8'(exp_amt)) begin
                errors++; $display("FAIL wrap_hit%0d: got valid %0b amount %0d expected valid 1 amount %0d",
                                   n, sif.scoreValid, sif.scoreAmount, exp_amt);
            end
            $display("wrap hit %0d credit 0 amount %0d", n, sif.scoreAmount);
            tick();
            tick();
            repeat (COOL) frame();
        end
    endtask

`ifdef CREDIT_BONUS_EN
    task automatic test_bonus();
        int exp_amt;
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        frames = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (bonusIndex !== 4'(i % 4)) begin
                errors++; $display("FAIL bonus_rot%0d: got %0d expected %0d", i, bonusIndex, i % 4);
            end
            frame();
            frame();
        end
        sif.scoreReady = 1'b1;
        creditIndex = 4'd3;
        for (int n = 0; n < 2; n++) begin
            exp_amt = (n + 1) * mult(3);
            collisionBallCredit = 1'b1;
            tick();
            collisionBallCredit = 1'b0;
            vectors++;
            if (sif.scoreAmount !== 8'(exp_amt)) begin
                errors++; $display("FAIL bonus_prep%0d: got %0d expected %0d", n, sif.scoreAmount, exp_amt);
            end
            tick();
            tick();
            repeat (COOL) frame();
        end
        vectors++;
        if (bonusIndex !== 4'd3) begin
            errors++; $display("FAIL bonus_idx: got %0d expected 3", bonusIndex);
        end
        collisionBallCredit = 1'b1;
        tick();
        collisionBallCredit = 1'b0;
        vectors++;
        if (sif.scoreValid !== 1'b1 || sif.scoreAmount !== 8'd6) begin
            errors++; $display("FAIL bonus_double: got valid %0b amount %0d expected valid 1 amount 6",
                               sif.scoreValid, sif.scoreAmount);
        end
        $display("bonus credit 3 amount %0d", sif.scoreAmount);
        tick();
        tick();
    endtask
`endif

    task automatic test_reset_mid_award();
        int bad = 0;
        sif.scoreReady = 1'b0;
        creditIndex = 4'd2;
        collisionBallCredit = 1'b1;
        tick();
        collisionBallCredit = 1'b0;
        vectors++;
        if (sif.scoreValid !== 1'b1) begin
            errors++; $display("FAIL midrst_pending: got valid %0b expected 1", sif.scoreValid);
        end
        #2;
        resetN = 1'b0;
        #1;
        vectors++;
        if (sif.scoreValid !== 1'b0 || sif.scoreAmount !== 8'd0) begin
            errors++; $display("FAIL midrst_async: got valid %0b amount %0d expected valid 0 amount 0",
                               sif.scoreValid, sif.scoreAmount);
        end
        for (int k = 0; k < NUM; k++) begin
            creditIndex = 4'(k);
            #1;
            vectors++;
            if (number !== 4'd1) begin
                errors++; $display("FAIL midrst_number[%0d]: got %0d expected 1", k, number);
            end
        end
        creditIndex = 4'd7;
        #1;
        vectors++;
        if (number !== 4'd1) begin
            errors++; $display("FAIL range_number: got %0d expected 1", number);
        end
        tick();
        resetN = 1'b1;
        frames = 0;
        sif.scoreReady = 1'b1;
        collisionBallCredit = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (sif.scoreValid !== 1'b0) bad++;
        end
        collisionBallCredit = 1'b0;
        vectors++;
        if (bad !== 0) begin
            errors++; $display("FAIL range_hit: got %0d award cycles expected 0", bad);
        end
        vectors++;
        if (bonusIndex !== 4'd0) begin
            errors++; $display("FAIL midrst_bonus: got %0d expected 0", bonusIndex);
        end
        creditIndex = 4'd2;
        collisionBallCredit = 1'b1;
        tick();
        collisionBallCredit = 1'b0;
        vectors++;
        if (sif.scoreValid !== 1'b1 || sif.scoreAmount !== 8'd1) begin
            errors++; $display("FAIL midrst_idle: got valid %0b amount %0d expected valid 1 amount 1",
                               sif.scoreValid, sif.scoreAmount);
        end
        tick();
        tick();
        $display("reset mid-award recovered, credit 2 amount 1");
    endtask

    initial begin
        sif.scoreReady = 1'b0;
        test_reset();
        test_single_hit();
        test_cooldown();
        test_stall();
        test_wrap();
`ifdef CREDIT_BONUS_EN
        test_bonus();
`endif
        test_reset_mid_award();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
